kwta_inhibitor: RTL and testbench
=================================

Name: kwta_inhibitor

Overview:
Clocked, parametrised lateral-inhibition stage for the temporal-coded (race-logic) column. Spikes are 1->0 transitions on N active-low lines. Within each gamma cycle the block passes only the K earliest spikes and inhibits all later ones. Inhibition is also triggered by an external inhibit or by a time-window cutoff. It sits between the column's neuron outputs and the downstream sorter/STDP logic, and reports the winner count and the first-spike time.

Parameters:
N, 16, number of spike lines
K, 1, max spikes admitted per gamma cycle (1..N)
TW, 6, width of gamma-cycle time counter
T_MAX, 39, last admissible tick; must be less than 2**TW
TIE_MODE, 0, 0 = lowest index wins ties (exactly K admitted); 1 = all spikes tied on the K-reaching tick admitted

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
gamma_start  in  1  one-cycle pulse; starts a new gamma cycle
inhibit  in  1  external inhibit, level; blocks admission while high
spikes_in  in  N  active-low spike lines; a 1->0 edge is a spike
spikes_out  out  N  active-low admitted spikes; latched low until next gamma_start
winners_cnt  out  $clog2(N+1)  number of spikes admitted this cycle
first_time  out  TW  tick of the first admitted spike
first_valid  out  1  first_time valid
done  out  1  high in INHIBITED state
timeout  out  1  INHIBITED was entered via T_MAX

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, tick=0, in_q=all ones.
  - spikes_out=all ones, winners_cnt=0, first_time=0.
  - first_valid=0, done=0, timeout=0.
- Edge detect: in_q registers spikes_in every cycle. fall[i] = in_q[i] & ~spikes_in[i]. A line already low at gamma_start never spikes.
- States:
  - IDLE: no admissions. gamma_start -> ACTIVE.
  - ACTIVE:
    - tick increments each cycle, starting at 0 in the cycle after gamma_start.
    - Candidate = fall masked by ~inhibit and by lines not yet admitted.
    - Admission is registered. spikes_out[i] goes low 1 cycle after the spikes_in[i] falling edge.
    - Go to INHIBITED when winners_cnt reaches K (same edge as the admission), when tick==T_MAX, or when inhibit=1.
  - INHIBITED: hold all outputs; done=1. gamma_start -> ACTIVE.
- gamma_start (any state, highest priority):
  - Clears tick, spikes_out, winners_cnt, first_valid, done and timeout.
  - Enters ACTIVE.
  - Edges in the gamma_start cycle are ignored.
- Ties, when more candidates arrive than K-winners_cnt remaining slots:
  - TIE_MODE=0: admit the lowest indices up to the remaining slots.
  - TIE_MODE=1: admit all of them; winners_cnt can exceed K, saturating at N.
- inhibit and a spike in the same cycle: inhibit wins; the spike is not admitted.
- T_MAX tick: spikes on that tick are admitted, then the state goes to INHIBITED with timeout=1. If K is also reached on that tick, timeout=0.
- first_time/first_valid: loaded with tick on the first admission of the cycle, held until gamma_start.
- Released lines (spikes_in back to 1) do not affect spikes_out; it stays latched until gamma_start.
- Reset mid-cycle: immediate clear to IDLE. The next gamma_start is required before any admission.

Test Plan:
- Single winner: N=16, K=1, TIE_MODE=0. gamma_start, then falls on line 1 at tick 5 and line 13 at tick 7. Expect only spikes_out[1] low from tick 6, winners_cnt=1, first_time=5, done=1, line 13 blocked.
- K=4 ordering: falls on lines 1, 13, 5, 12, 4 at ticks 5, 7, 10, 11, 15. Expect lines 1, 13, 5, 12 admitted; line 4 blocked; winners_cnt=4; done from tick 12.
- External inhibit: K=4, falls on line 1 at tick 5 and line 13 at tick 7, inhibit=1 at tick 17, fall on line 3 at tick 20. Expect lines 1 and 13 admitted, line 3 blocked, winners_cnt=2, done=1, timeout=0.
- Tie: K=2, lines 9, 3 and 6 fall on the same tick 4. With TIE_MODE=0 expect lines 3 and 6 admitted, winners_cnt=2. With TIE_MODE=1 expect all three admitted, winners_cnt=3.
- Timeout: T_MAX=39, no spikes. Expect done=1 and timeout=1 after tick 39, spikes_out all ones. A spike at tick 40 is not admitted.
- Re-arm/reset: gamma_start mid-ACTIVE clears outputs, and line 2 falling at the next tick 3 is admitted. rst_n low mid-cycle forces all outputs to reset values asynchronously, and spikes are ignored until gamma_start.

Source files
------------

// File: rtl/kwta_inhibitor_if.sv
// Spike-path bundle for the k-WTA inhibitor: spike/control inputs and the
// admitted-spike, winner-count and first-spike-time results.
interface kwta_inhibitor_if #(
  parameter int N  = 16,
  parameter int TW = 6
);
  localparam int CW = $clog2(N + 1);

  logic          gamma_start;
  logic          inhibit;
  logic [N-1:0]  spikes_in;
  logic [N-1:0]  spikes_out;
  logic [CW-1:0] winners_cnt;
  logic [TW-1:0] first_time;
  logic          first_valid;
  logic          done;
  logic          timeout;

  modport master (
    output gamma_start, inhibit, spikes_in,
    input  spikes_out, winners_cnt, first_time, first_valid, done, timeout
  );

  modport slave (
    input  gamma_start, inhibit, spikes_in,
    output spikes_out, winners_cnt, first_time, first_valid, done, timeout
  );
endinterface

// File: rtl/kwta_inhibitor.sv
// Race-logic lateral inhibition: within a gamma cycle admit only the K earliest
// active-low spikes, then inhibit on K winners, external inhibit or T_MAX.
module kwta_inhibitor #(
  parameter int N        = 16,
  parameter int K        = 1,
  parameter int TW       = 6,
  parameter int T_MAX    = 39,
  parameter int TIE_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  kwta_inhibitor_if.slave     bus,
  output logic [1:0]          state_dbg
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_INHIB  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [N-1:0]  in_q;
  logic [N-1:0]  adm_q, adm_d;   // 1 = line admitted this gamma cycle
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] ft_q, ft_d;
  logic          fv_q, fv_d;
  logic          done_q, done_d;
  logic          to_q, to_d;

  logic [N-1:0]  fall;
  logic [N-1:0]  cand;
  logic [N-1:0]  grant;
  logic [CW-1:0] n_grant;
  logic [CW-1:0] cnt_new;
  logic          k_hit;
  logic          t_hit;

  // Candidate selection: scanning from index 0 gives lowest-index priority on ties.
  always_comb begin
    fall    = in_q & ~bus.spikes_in;
    cand    = '0;
    grant   = '0;
    n_grant = '0;
    if (state_q == S_ACTIVE && !bus.inhibit) begin
      cand = fall & ~adm_q;
    end
    for (int i = 0; i < N; i++) begin
      if (cand[i] && (TIE_MODE != 0 || (int'(cnt_q) + int'(n_grant)) < K)) begin
        grant[i] = 1'b1;
        n_grant  = n_grant + CW'(1);
      end
    end
    cnt_new = cnt_q + n_grant;
    k_hit   = int'(cnt_new) >= K;
    t_hit   = tick_q == TW'(T_MAX);
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    adm_d   = adm_q;
    cnt_d   = cnt_q;
    ft_d    = ft_q;
    fv_d    = fv_q;
    done_d  = done_q;
    to_d    = to_q;
    if (bus.gamma_start) begin
      // first_time is deliberately kept; first_valid qualifies it.
      state_d = S_ACTIVE;
      tick_d  = '0;
      adm_d   = '0;
      cnt_d   = '0;
      fv_d    = 1'b0;
      done_d  = 1'b0;
      to_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ACTIVE: begin
          adm_d = adm_q | grant;
          cnt_d = cnt_new;
          if (n_grant != '0 && !fv_q) begin
            fv_d = 1'b1;
            ft_d = tick_q;
          end
          if (k_hit || t_hit || bus.inhibit) begin
            state_d = S_INHIB;
            done_d  = 1'b1;
            to_d    = t_hit && !k_hit && !bus.inhibit;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_INHIB: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      in_q    <= '1;
      adm_q   <= '0;
      cnt_q   <= '0;
      ft_q    <= '0;
      fv_q    <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      in_q    <= bus.spikes_in;
      adm_q   <= adm_d;
      cnt_q   <= cnt_d;
      ft_q    <= ft_d;
      fv_q    <= fv_d;
      done_q  <= done_d;
      to_q    <= to_d;
    end
  end

  assign bus.spikes_out  = ~adm_q;
  assign bus.winners_cnt = cnt_q;
  assign bus.first_time  = ft_q;
  assign bus.first_valid = fv_q;
  assign bus.done        = done_q;
  assign bus.timeout     = to_q;
  assign state_dbg       = state_q;
endmodule

// File: tb/tb_kwta_inhibitor.sv
// Bench for kwta_inhibitor: four configurations share one stimulus stream and
// are compared every cycle against a queue-based spike-race model.
module tb_kwta_inhibitor;
  localparam int N = 16;
  localparam int TW = 6;
  localparam int TMAX = 39;
  localparam int OW = 16 + 5 + 6 + 3;

  logic clk;
  logic rst_n;
  logic gs, inh;
  logic [N-1:0] sp;
  logic [1:0] st0, st1, st2, st3;

  int checks = 0;
  int failures = 0;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  kwta_inhibitor_if #(.N(N), .TW(TW)) if0 ();
  kwta_inhibitor_if #(.N(N), .TW(TW)) if1 ();
  kwta_inhibitor_if #(.N(N), .TW(TW)) if2 ();
  kwta_inhibitor_if #(.N(N), .TW(TW)) if3 ();

  assign if0.gamma_start = gs; assign if0.inhibit = inh; assign if0.spikes_in = sp;
  assign if1.gamma_start = gs; assign if1.inhibit = inh; assign if1.spikes_in = sp;
  assign if2.gamma_start = gs; assign if2.inhibit = inh; assign if2.spikes_in = sp;
  assign if3.gamma_start = gs; assign if3.inhibit = inh; assign if3.spikes_in = sp;

  kwta_inhibitor #(.N(N), .K(1), .TW(TW), .T_MAX(TMAX), .TIE_MODE(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0), .state_dbg(st0));
  kwta_inhibitor #(.N(N), .K(4), .TW(TW), .T_MAX(TMAX), .TIE_MODE(0))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1), .state_dbg(st1));
  kwta_inhibitor #(.N(N), .K(2), .TW(TW), .T_MAX(TMAX), .TIE_MODE(0))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(if2), .state_dbg(st2));
  kwta_inhibitor #(.N(N), .K(2), .TW(TW), .T_MAX(TMAX), .TIE_MODE(1))
    dut3 (.clk(clk), .rst_n(rst_n), .bus(if3), .state_dbg(st3));

  // reference model: per-configuration gamma-cycle bookkeeping
  int mk[4] = '{1, 4, 2, 2};
  int mt[4] = '{0, 0, 0, 1};
  bit          m_act[4];
  bit          m_done[4];
  bit          m_to[4];
  bit          m_fv[4];
  int          m_ft[4];
  int          m_cnt[4];
  int          m_tick[4];
  logic [N-1:0] m_adm[4];
  logic [N-1:0] m_inq;

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_act[c] = 0; m_done[c] = 0; m_to[c] = 0; m_fv[c] = 0;
      m_ft[c] = 0; m_cnt[c] = 0; m_tick[c] = 0; m_adm[c] = '0;
    end
    m_inq = '1;
  endtask

  task automatic model_step(bit g, bit i, logic [N-1:0] s);
    int q[$];
    int slots;
    for (int c = 0; c < 4; c++) begin
      if (g) begin
        m_act[c] = 1; m_done[c] = 0; m_to[c] = 0; m_fv[c] = 0;
        m_cnt[c] = 0; m_tick[c] = 0; m_adm[c] = '0;
      end else if (m_act[c]) begin
        q.delete();
        if (!i) begin
          for (int b = 0; b < N; b++)
            if (m_inq[b] && !s[b] && !m_adm[c][b]) q.push_back(b);
        end
        slots = mk[c] - m_cnt[c];
        if (mt[c] == 0) while (q.size() > slots) void'(q.pop_back());
        if (q.size() > 0 && !m_fv[c]) begin
          m_fv[c] = 1;
          m_ft[c] = m_tick[c];
        end
        foreach (q[j]) m_adm[c][q[j]] = 1'b1;
        m_cnt[c] += q.size();
        if (m_cnt[c] >= mk[c] || i || m_tick[c] == TMAX) begin
          m_act[c]  = 0;
          m_done[c] = 1;
          m_to[c]   = (m_tick[c] == TMAX) && (m_cnt[c] < mk[c]) && !i;
        end else begin
          m_tick[c]++;
        end
      end
    end
    m_inq = s;
  endtask

  function automatic logic [OW-1:0] model_out(int c);
    return {~m_adm[c], 5'(m_cnt[c]), 6'(m_ft[c]), m_fv[c], m_done[c], m_to[c]};
  endfunction

  function automatic logic [OW-1:0] dut_out(int c);
    logic [OW-1:0] o;
    case (c)
      0: o = {if0.spikes_out, if0.winners_cnt, if0.first_time, if0.first_valid, if0.done, if0.timeout};
      1: o = {if1.spikes_out, if1.winners_cnt, if1.first_time, if1.first_valid, if1.done, if1.timeout};
      2: o = {if2.spikes_out, if2.winners_cnt, if2.first_time, if2.first_valid, if2.done, if2.timeout};
      default: o = {if3.spikes_out, if3.winners_cnt, if3.first_time, if3.first_valid, if3.done, if3.timeout};
    endcase
    return o;
  endfunction

  // scoreboard
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // driver tasks: strict alternation observe() then drive()
  task automatic observe();
    @(negedge clk);
    for (int c = 0; c < 4; c++) check($sformatf("model_cfg%0d", c), 64'(dut_out(c)), 64'(model_out(c)));
  endtask

  task automatic drive(bit g, bit i, logic [N-1:0] s);
    gs = g; inh = i; sp = s;
    model_step(g, i, s);
  endtask

  task automatic check_fields(string tag, int c, logic [N-1:0] so, int cnt, int ft, bit fv, bit dn, bit to);
    logic [OW-1:0] o;
    o = dut_out(c);
    check({tag, "_spikes_out"}, 64'(o[OW-1 -: 16]), 64'(so));
    check({tag, "_winners_cnt"}, 64'(o[13:9]), 64'(cnt));
    check({tag, "_first_valid"}, 64'(o[2]), 64'(fv));
    if (fv) check({tag, "_first_time"}, 64'(o[8:3]), 64'(ft));
    check({tag, "_done"}, 64'(o[1]), 64'(dn));
    check({tag, "_timeout"}, 64'(o[0]), 64'(to));
  endtask

  typedef struct {
    int          cfg;
    int          ln[5];
    int          tk[5];
    int          inh_t;
    int          len;
    logic [15:0] e_so;
    int          e_cnt;
    int          e_ft;
    bit          e_fv;
    bit          e_done;
    bit          e_to;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [N-1:0] s;
    bit i;
    tbl[0] = '{0, '{1, 13, -1, -1, -1}, '{5, 7, 0, 0, 0},    -1, 10, 16'hFFFD, 1, 5, 1, 1, 0};
    tbl[1] = '{1, '{1, 13, 5, 12, 4},   '{5, 7, 10, 11, 15}, -1, 20, 16'hCFDD, 4, 5, 1, 1, 0};
    tbl[2] = '{1, '{1, 13, 3, -1, -1},  '{5, 7, 20, 0, 0},   17, 25, 16'hDFFD, 2, 5, 1, 1, 0};
    tbl[3] = '{2, '{9, 3, 6, -1, -1},   '{4, 4, 4, 0, 0},    -1, 10, 16'hFFB7, 2, 4, 1, 1, 0};
    tbl[4] = '{3, '{9, 3, 6, -1, -1},   '{4, 4, 4, 0, 0},    -1, 10, 16'hFDB7, 3, 4, 1, 1, 0};
    tbl[5] = '{0, '{2, -1, -1, -1, -1}, '{40, 0, 0, 0, 0},   -1, 46, 16'hFFFF, 0, 0, 0, 1, 1};

    rst_n = 1'b0; gs = 0; inh = 0; sp = '1;
    model_reset();
    repeat (2) @(negedge clk);
    check_fields("reset", 0, 16'hFFFF, 0, 0, 0, 0, 0);
    check("reset_first_time", 64'(if0.first_time), 64'(0));
    rst_n = 1'b1;
    drive(0, 0, '1);

    // table-driven scenarios
    for (int v = 0; v < 6; v++) begin
      observe();
      drive(1, 0, '1);
      for (int t = 0; t < tbl[v].len; t++) begin
        s = '1;
        for (int e = 0; e < 5; e++)
          if (tbl[v].ln[e] >= 0 && tbl[v].tk[e] <= t) s[tbl[v].ln[e]] = 1'b0;
        i = (tbl[v].inh_t >= 0) && (t >= tbl[v].inh_t);
        observe();
        drive(0, i, s);
      end
      observe();
      check_fields($sformatf("vec%0d", v), tbl[v].cfg, tbl[v].e_so, tbl[v].e_cnt,
                   tbl[v].e_ft, tbl[v].e_fv, tbl[v].e_done, tbl[v].e_to);
      drive(0, inh, sp);
    end

    // re-arm: gamma_start mid-ACTIVE, then line 2 at new tick 3
    observe(); drive(1, 0, '1);
    for (int t = 0; t < 4; t++) begin
      observe(); drive(0, 0, (t >= 2) ? 16'hFFDF : 16'hFFFF);
    end
    observe(); drive(1, 0, 16'hFFDF);
    observe();
    check_fields("rearm_clear", 1, 16'hFFFF, 0, 0, 0, 0, 0);
    drive(0, 0, 16'hFFDF);
    for (int t = 1; t < 4; t++) begin
      observe(); drive(0, 0, (t == 3) ? 16'hFFDB : 16'hFFDF);
    end
    observe();
    check_fields("rearm_line2", 1, 16'hFFFB, 1, 3, 1, 0, 0);
    drive(0, 0, 16'hFFDB);

    // asynchronous reset mid-cycle, then spikes ignored until gamma_start
    observe(); drive(1, 0, '1);
    observe(); drive(0, 0, 16'hFF7F);
    observe(); drive(0, 0, 16'hFF7F);
    #2 rst_n = 1'b0;
    #1;
    check_fields("async_rst", 1, 16'hFFFF, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 16'hFEFF);
    for (int t = 0; t < 4; t++) begin
      observe(); drive(0, 0, (t >= 1) ? 16'hF0FF : 16'hFEFF);
    end
    observe();
    check_fields("post_rst_idle", 0, 16'hFFFF, 0, 0, 0, 0, 0);
    drive(0, 0, '1);

    // randomized stream against the model
    s = '1;
    for (int n = 0; n < 800; n++) begin
      observe();
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 19) == 0) s[b] = ~s[b];
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0, s);
    end
    observe();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
